// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared types and constants for the mux scan sequencer.
//   - state_t    : sequencer FSM encoding (IDLE / SCAN / HOLD)
//   - SETTLE_MAX : largest supported settle time in cycles
//   - CNT_W      : width of the settle counter
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/mux_settle_cnt.sv
// mux_settle_cnt
//   Settle-window counter. Counts while enabled and wraps to zero on the
//   cycle it reaches SETTLE; done_o flags that final cycle of the window.
// Ports
//   clk_i   : clock, rising edge
//   rstn_i  : synchronous active-low reset
//   clr_i   : synchronous clear (takes priority over en_i)
//   en_i    : advance the counter
//   done_o  : counter currently equals SETTLE
module mux_settle_cnt
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear, wrap at SETTLE, or increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == SETTLE_C) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == SETTLE_C);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Sweeps the select of an external bit mux over inputs 0..N_IN-1, holds
//   each select for SETTLE+1 cycles, samples mux_y at the end of each window
//   and presents the assembled word on a valid/ready handshake.
// Ports
//   clk        : clock, rising edge
//   rstn       : synchronous active-low reset
//   start      : scan request, accepted only when idle
//   busy       : high while scanning or holding a word
//   sel        : select driven to the mux
//   mux_y      : mux output
//   out_data   : bit i = mux_y sampled while sel == i
//   out_valid  : word available
//   out_ready  : downstream accepts when out_valid && out_ready
//   out_parity : ^out_data (only when MUX_SCAN_PARITY_EN is defined)
// Configuration
//   MUX_SCAN_PARITY_EN : adds the registered out_parity output.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_y,
  output logic [N_IN-1:0]  out_data,
  output logic             out_valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             out_ready
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_IN-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             parity_q, parity_d;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             settle_done_s;

  mux_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle_cnt (
    .clk_i  (clk),
    .rstn_i (rstn),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .done_o (settle_done_s)
  );

  // next-state, select, capture and handshake logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    parity_d  = parity_q;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          sel_d     = '0;
          data_d    = '0;
          busy_d    = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        cnt_en_s = 1'b1;
        if (settle_done_s) begin
          for (int i = 0; i < int'(N_IN); i++) begin
            if (sel_q == SEL_W'(i)) begin
              data_d[i] = mux_y;
            end
          end
          // last input: stop the sweep at N_IN-1 rather than wrapping through unused codes
          if (sel_q == SEL_LAST) begin
            state_d  = HOLD;
            sel_d    = '0;
            valid_d  = 1'b1;
            parity_d = ^data_d;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          sel_d = sel_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      parity_q <= parity_d;
    end
  end

  assign busy      = busy_q;
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

`ifdef MUX_SCAN_PARITY_EN
  assign out_parity = parity_q;
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_q;
`endif

endmodule
